// File: rtl/imem_loader_if.sv
// imem_loader_if: groups the loader's host byte stream, control and instruction-memory write
// signals.
//   rx_valid/rx_data/rx_ready : byte stream handshake from the host link
//   start                     : restart pulse for a new load
//   imem_we/imem_addr/imem_wdata : instruction-memory write port
//   core_rst/load_done/load_err  : pipeline reset and load status
// Modports: master = loader side, slave = host/memory side.
interface imem_loader_if #(
    parameter int unsigned ADDR_WIDTH = 10
);
    logic                  rx_valid;
    logic [7:0]            rx_data;
    logic                  rx_ready;
    logic                  start;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_wdata;
    logic                  core_rst;
    logic                  load_done;
    logic                  load_err;

    modport master (
        input  rx_valid, rx_data, start,
        output rx_ready, imem_we, imem_addr, imem_wdata, core_rst, load_done, load_err
    );

    modport slave (
        output rx_valid, rx_data, start,
        input  rx_ready, imem_we, imem_addr, imem_wdata, core_rst, load_done, load_err
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: receives a length-prefixed byte image from a host link, assembles little-endian
// 32-bit words, writes them to consecutive instruction-memory word addresses, and verifies an
// XOR checksum over the data bytes. The core is held in reset until the load succeeds.
// Ports:
//   clk : system clock
//   rst : asynchronous active-high reset
//   bus : imem_loader_if.master (byte stream in, start pulse in, imem write port and status out)
module imem_loader #(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic          clk,
    input  logic          rst,
    imem_loader_if.master bus
);

    typedef enum logic [2:0] {
        StLen0, StLen1, StData, StWrite, StCsum, StDone, StErr
    } stateT;

    localparam logic [16:0] Capacity = 17'(2 ** ADDR_WIDTH);

    stateT                 stateQ, stateD;
    logic [7:0]            lenLo;
    logic [15:0]           len;
    logic [1:0]            byteCnt;
    logic [ADDR_WIDTH-1:0] wordCnt;
    logic [31:0]           wordBuf;
    logic [7:0]            csum;
    logic                  imemWeQ;
    logic [ADDR_WIDTH-1:0] imemAddrQ;
    logic [31:0]           imemWdataQ;

    logic                  rxReady, coreRst, loadDone, loadErr;
    logic                  accept;
    logic [15:0]           nextLen;
    logic                  lastWord;

    assign accept   = bus.rx_valid & rxReady;
    assign nextLen  = {bus.rx_data, lenLo};
    assign lastWord = (16'(wordCnt) == (len - 16'd1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ <= StLen0;
        end else begin
            stateQ <= stateD;
        end
    end

    // Next-state logic
    always_comb begin
        stateD = stateQ;
        case (stateQ)
            StLen0:  if (accept) stateD = StLen1;
            StLen1: begin
                if (accept) begin
                    if ({1'b0, nextLen} > Capacity) begin
                        stateD = StErr;
                    end else if (nextLen == 16'd0) begin
                        stateD = StCsum;
                    end else begin
                        stateD = StData;
                    end
                end
            end
            StData:  if (accept && (byteCnt == 2'd3)) stateD = StWrite;
            StWrite: stateD = lastWord ? StCsum : StData;
            StCsum:  if (accept) stateD = (bus.rx_data == csum) ? StDone : StErr;
            StDone:  if (bus.start) stateD = StLen0;
            StErr:   if (bus.start) stateD = StLen0;
            default: stateD = StLen0;
        endcase
    end

    // Moore outputs; rx_ready depends on state only
    always_comb begin
        rxReady  = 1'b0;
        coreRst  = 1'b1;
        loadDone = 1'b0;
        loadErr  = 1'b0;
        case (stateQ)
            StLen0, StLen1, StData, StCsum: rxReady = 1'b1;
            StDone: begin
                coreRst  = 1'b0;
                loadDone = 1'b1;
            end
            StErr:   loadErr = 1'b1;
            default: ;
        endcase
    end

    // Datapath: length, assembly buffer, checksum, counters and registered write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lenLo      <= '0;
            len        <= '0;
            byteCnt    <= '0;
            wordCnt    <= '0;
            wordBuf    <= '0;
            csum       <= '0;
            imemWeQ    <= 1'b0;
            imemAddrQ  <= '0;
            imemWdataQ <= '0;
        end else begin
            case (stateQ)
                StLen0: if (accept) lenLo <= bus.rx_data;
                StLen1: if (accept) len <= nextLen;
                StData: begin
                    if (accept) begin
                        wordBuf[{byteCnt, 3'b000} +: 8] <= bus.rx_data;
                        csum    <= csum ^ bus.rx_data;
                        byteCnt <= byteCnt + 2'd1;
                        // Load the write port on the way into WRITE so the strobe is registered
                        if (byteCnt == 2'd3) begin
                            imemWeQ    <= 1'b1;
                            imemAddrQ  <= wordCnt;
                            imemWdataQ <= {bus.rx_data, wordBuf[23:0]};
                        end
                    end
                end
                StWrite: begin
                    imemWeQ <= 1'b0;
                    wordCnt <= wordCnt + 1'b1;
                end
                StDone, StErr: begin
                    if (bus.start) begin
                        byteCnt   <= '0;
                        wordCnt   <= '0;
                        csum      <= '0;
                        imemAddrQ <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.rx_ready   = rxReady;
    assign bus.imem_we    = imemWeQ;
    assign bus.imem_addr  = imemAddrQ;
    assign bus.imem_wdata = imemWdataQ;
    assign bus.core_rst   = coreRst;
    assign bus.load_done  = loadDone;
    assign bus.load_err   = loadErr;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed bench for imem_loader. Two instances: ADDR_WIDTH=10 (sel=0) and
// ADDR_WIDTH=2 (sel=1); sel routes stimulus to one of them and observation from it.
module tb_imem_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sel = 1'b0;
    logic       rxValid = 1'b0;
    logic       startR = 1'b0;
    logic [7:0] rxData = 8'h00;

    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_WIDTH(10)) ifA ();
    imem_loader_if #(.ADDR_WIDTH(2))  ifB ();

    assign ifA.rx_valid = rxValid & ~sel;
    assign ifA.rx_data  = rxData;
    assign ifA.start    = startR & ~sel;
    assign ifB.rx_valid = rxValid & sel;
    assign ifB.rx_data  = rxData;
    assign ifB.start    = startR & sel;

    imem_loader #(.ADDR_WIDTH(10)) dutA (.clk(clk), .rst(rst), .bus(ifA));
    imem_loader #(.ADDR_WIDTH(2))  dutB (.clk(clk), .rst(rst), .bus(ifB));

    logic        obsReady, obsWe, obsCoreRst, obsDone, obsErr;
    logic [9:0]  obsAddr;
    logic [31:0] obsWdata;
    assign obsReady   = sel ? ifB.rx_ready   : ifA.rx_ready;
    assign obsWe      = sel ? ifB.imem_we    : ifA.imem_we;
    assign obsCoreRst = sel ? ifB.core_rst   : ifA.core_rst;
    assign obsDone    = sel ? ifB.load_done  : ifA.load_done;
    assign obsErr     = sel ? ifB.load_err   : ifA.load_err;
    assign obsAddr    = sel ? {8'b0, ifB.imem_addr} : ifA.imem_addr;
    assign obsWdata   = sel ? ifB.imem_wdata : ifA.imem_wdata;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Write monitor and rx_ready legality
    logic [9:0]  wrAddr[$];
    logic [31:0] wrData[$];
    int          weRun = 0;
    int          badReady = 0;
    logic        prevWe = 1'b0;

    always @(negedge clk) begin
        if (obsWe) begin
            wrAddr.push_back(obsAddr);
            wrData.push_back(obsWdata);
        end
        if (obsWe && prevWe) weRun++;
        if (!rst && !obsReady && !obsWe && !obsDone && !obsErr) badReady++;
        if (obsWe && obsReady) badReady++;
        prevWe = obsWe;
    end

    // Called at a negedge; returns at the negedge after the byte was consumed.
    task automatic sendByte(input logic [7:0] b);
        int budget;
        budget = 0;
        rxData  = b;
        rxValid = 1'b1;
        while (!obsReady && budget < 16) begin
            @(negedge clk);
            budget++;
        end
        if (!obsReady) check("accept_timeout", 32'd0, 32'd1);
        @(negedge clk);
        rxValid = 1'b0;
    endtask

    task automatic startPulse(input string tag);
        startR = 1'b1;
        @(negedge clk);
        startR = 1'b0;
        check({tag, "_start_corerst"}, 32'(obsCoreRst), 32'd1);
        check({tag, "_start_done"},    32'(obsDone),    32'd0);
        check({tag, "_start_err"},     32'(obsErr),     32'd0);
        check({tag, "_start_ready"},   32'(obsReady),   32'd1);
        check({tag, "_start_addr"},    32'(obsAddr),    32'd0);
    endtask

    typedef struct {
        logic        sel;
        logic [7:0]  lenLo;
        logic [7:0]  lenHi;
        int          nData;
        logic [63:0] data;      // byte i at [8*i +: 8]
        logic [7:0]  csum;
        logic        lenOnly;   // length rejected, no further bytes
        logic        expDone;
        int          expWrites;
        logic [31:0] w0;
        logic [31:0] w1;
    } vecT;

    vecT vecs[7];

    task automatic runVec(input vecT v, input string tag);
        int base;
        sel = v.sel;
        startPulse(tag);
        base = wrAddr.size();
        sendByte(v.lenLo);
        sendByte(v.lenHi);
        if (v.lenOnly) begin
            check({tag, "_len_err"},   32'(obsErr),   32'd1);
            check({tag, "_len_done"},  32'(obsDone),  32'd0);
            check({tag, "_len_ready"}, 32'(obsReady), 32'd0);
        end else begin
            for (int i = 0; i < v.nData; i++) begin
                sendByte(v.data[8*i +: 8]);
                if (i % 4 == 3) begin
                    check($sformatf("%s_we%0d", tag, i / 4), 32'(obsWe), 32'd1);
                    check($sformatf("%s_addr%0d", tag, i / 4), 32'(obsAddr), 32'(i / 4));
                    check($sformatf("%s_wdata%0d", tag, i / 4), obsWdata,
                          (i / 4 == 0) ? v.w0 : v.w1);
                end
            end
            sendByte(v.csum);
            check({tag, "_done"},    32'(obsDone),    32'(v.expDone));
            check({tag, "_err"},     32'(obsErr),     32'(!v.expDone));
            check({tag, "_corerst"}, 32'(obsCoreRst), 32'(!v.expDone));
            check({tag, "_ready"},   32'(obsReady),   32'd0);
        end
        check({tag, "_nwrites"}, 32'(wrAddr.size() - base), 32'(v.expWrites));
        for (int k = 0; k < v.expWrites && (base + k) < wrAddr.size(); k++) begin
            check($sformatf("%s_mon_addr%0d", tag, k), 32'(wrAddr[base + k]), 32'(k));
            check($sformatf("%s_mon_data%0d", tag, k), wrData[base + k],
                  (k == 0) ? v.w0 : v.w1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [7:0] streamA[13];

        //        sel  lo     hi     n  data                    csum   lenOnly done wr w0            w1
        vecs[0] = '{1'b0, 8'h02, 8'h00, 8, 64'h00A00113_00500093, 8'h71, 1'b0, 1'b1, 2,
                    32'h00500093, 32'h00A00113};
        vecs[1] = '{1'b0, 8'h02, 8'h00, 8, 64'h00A00113_00500093, 8'h70, 1'b0, 1'b0, 2,
                    32'h00500093, 32'h00A00113};
        vecs[2] = '{1'b0, 8'h00, 8'h00, 0, 64'h0, 8'h00, 1'b0, 1'b1, 0, 32'h0, 32'h0};
        vecs[3] = '{1'b0, 8'h00, 8'h00, 0, 64'h0, 8'h5A, 1'b0, 1'b0, 0, 32'h0, 32'h0};
        vecs[4] = '{1'b0, 8'h01, 8'h04, 0, 64'h0, 8'h00, 1'b1, 1'b0, 0, 32'h0, 32'h0};
        vecs[5] = '{1'b1, 8'h05, 8'h00, 0, 64'h0, 8'h00, 1'b1, 1'b0, 0, 32'h0, 32'h0};
        vecs[6] = '{1'b1, 8'h01, 8'h00, 4, 64'h00000000_12345678, 8'h08, 1'b0, 1'b1, 1,
                    32'h12345678, 32'h0};
        streamA = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00,
                    8'h71, 8'h00, 8'h00};

        // Reset values
        #1;
        check("rst_ready",   32'(obsReady),   32'd1);
        check("rst_we",      32'(obsWe),      32'd0);
        check("rst_addr",    32'(obsAddr),    32'd0);
        check("rst_wdata",   obsWdata,        32'd0);
        check("rst_corerst", 32'(obsCoreRst), 32'd1);
        check("rst_done",    32'(obsDone),    32'd0);
        check("rst_err",     32'(obsErr),     32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 7; v++) begin
            runVec(vecs[v], $sformatf("v%0d", v));
        end

        // Full capacity on the 4-word instance: addresses 0..3, no wrap to 0
        sel = 1'b1;
        startPulse("full");
        base = wrAddr.size();
        sendByte(8'h04);
        sendByte(8'h00);
        for (int i = 0; i < 16; i++) begin
            sendByte(8'h10 + 8'(i));
        end
        sendByte(8'h00);
        check("full_done", 32'(obsDone), 32'd1);
        check("full_nwrites", 32'(wrAddr.size() - base), 32'd4);
        for (int k = 0; k < 4 && (base + k) < wrAddr.size(); k++) begin
            check($sformatf("full_addr%0d", k), 32'(wrAddr[base + k]), 32'(k));
        end
        if (wrAddr.size() >= base + 4) begin
            check("full_data0", wrData[base + 0], 32'h13121110);
            check("full_data3", wrData[base + 3], 32'h1F1E1D1C);
        end

        // Backpressure: random gaps, but the first byte of each word arrives during WRITE
        sel = 1'b0;
        startPulse("bp");
        base = wrAddr.size();
        for (int i = 0; i < 11; i++) begin
            if (i >= 2 && i < 10 && ((i - 2) % 4) == 0) begin
                sendByte(streamA[i]);
            end else begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                sendByte(streamA[i]);
            end
        end
        check("bp_done", 32'(obsDone), 32'd1);
        check("bp_nwrites", 32'(wrAddr.size() - base), 32'd2);
        if (wrAddr.size() >= base + 2) begin
            check("bp_data0", wrData[base + 0], 32'h00500093);
            check("bp_data1", wrData[base + 1], 32'h00A00113);
            check("bp_addr1", 32'(wrAddr[base + 1]), 32'd1);
        end

        // start together with a valid byte in DONE: byte must survive into LEN0
        rxData  = 8'h02;
        rxValid = 1'b1;
        startR  = 1'b1;
        @(negedge clk);
        startR = 1'b0;
        check("simul_ready", 32'(obsReady), 32'd1);
        check("simul_done",  32'(obsDone),  32'd0);
        base = wrAddr.size();
        for (int i = 0; i < 11; i++) begin
            sendByte(streamA[i]);
        end
        check("simul_load_done", 32'(obsDone), 32'd1);
        check("simul_nwrites", 32'(wrAddr.size() - base), 32'd2);

        // Asynchronous reset after 5 bytes of a new load
        startPulse("ar");
        for (int i = 0; i < 5; i++) begin
            sendByte(streamA[i]);
        end
        #2 rst = 1'b1;
        #1;
        check("ar_ready",   32'(obsReady),   32'd1);
        check("ar_we",      32'(obsWe),      32'd0);
        check("ar_addr",    32'(obsAddr),    32'd0);
        check("ar_wdata",   obsWdata,        32'd0);
        check("ar_corerst", 32'(obsCoreRst), 32'd1);
        check("ar_done",    32'(obsDone),    32'd0);
        check("ar_err",     32'(obsErr),     32'd0);
        @(negedge clk);
        rst = 1'b0;
        runVec(vecs[0], "after_rst");

        check("we_single_cycle", 32'(weRun), 32'd0);
        check("ready_legal", 32'(badReady), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
